// File: rtl/minisys_pkg.sv
// Shared definitions for the minisys1a boot path: widths, memory address size
// and the state encodings used by the UART program loader.
package minisys_pkg;
    localparam int BYTE_W      = 8;
    localparam int WORD_W      = 32;
    localparam int IMEM_ADDR_W = 14;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } ld_state_t;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;
endpackage

// File: rtl/uart_rx_byte.sv
// 16x oversampling 8N1 UART receiver; emits one-cycle byte_vld or frm_err
// pulses at the middle of the stop bit.
module uart_rx_byte
    import minisys_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [BYTE_W-1:0] data,
    output logic              byte_vld,
    output logic              frm_err
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic              rx_meta_r, rx_sync_r, rx_prev_r;
    logic [TW-1:0]     tick_cnt_r;
    logic              tick_s;
    rx_state_t         rstate_r, rstate_nxt_s;
    logic [3:0]        samp_cnt_r, samp_nxt_s;
    logic [2:0]        bit_idx_r, bit_nxt_s;
    logic [BYTE_W-1:0] shift_r, shift_nxt_s;
    logic              vld_r, vld_nxt_s, ferr_r, ferr_nxt_s;

    assign tick_s   = (tick_cnt_r == TW'(TICK_DIV - 1));
    assign data     = shift_r;
    assign byte_vld = vld_r;
    assign frm_err  = ferr_r;

    // Synchronise the line (idle-high preset) and run the oversample tick
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_r  <= 1'b1;
            rx_sync_r  <= 1'b1;
            rx_prev_r  <= 1'b1;
            tick_cnt_r <= '0;
        end else begin
            rx_meta_r  <= rx;
            rx_sync_r  <= rx_meta_r;
            rx_prev_r  <= rx_sync_r;
            tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TW'(1);
        end
    end

    // Receiver state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            rstate_r   <= R_IDLE;
            samp_cnt_r <= 4'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= '0;
            vld_r      <= 1'b0;
            ferr_r     <= 1'b0;
        end else begin
            rstate_r   <= rstate_nxt_s;
            samp_cnt_r <= samp_nxt_s;
            bit_idx_r  <= bit_nxt_s;
            shift_r    <= shift_nxt_s;
            vld_r      <= vld_nxt_s;
            ferr_r     <= ferr_nxt_s;
        end
    end

    // Start qualification at sample 8, then one sample every 16 ticks
    always_comb begin
        rstate_nxt_s = rstate_r;
        samp_nxt_s   = samp_cnt_r;
        bit_nxt_s    = bit_idx_r;
        shift_nxt_s  = shift_r;
        vld_nxt_s    = 1'b0;
        ferr_nxt_s   = 1'b0;
        case (rstate_r)
            R_IDLE: begin
                if (rx_prev_r && !rx_sync_r) begin
                    rstate_nxt_s = R_START;
                    samp_nxt_s   = 4'd0;
                end else begin
                    rstate_nxt_s = R_IDLE;
                end
            end
            R_START: begin
                if (tick_s && (samp_cnt_r == 4'd7)) begin
                    rstate_nxt_s = rx_sync_r ? R_IDLE : R_DATA;
                    samp_nxt_s   = 4'd0;
                    bit_nxt_s    = 3'd0;
                end else if (tick_s) begin
                    samp_nxt_s = samp_cnt_r + 4'd1;
                end else begin
                    samp_nxt_s = samp_cnt_r;
                end
            end
            R_DATA: begin
                if (tick_s && (samp_cnt_r == 4'd15)) begin
                    shift_nxt_s  = {rx_sync_r, shift_r[BYTE_W-1:1]};
                    samp_nxt_s   = 4'd0;
                    bit_nxt_s    = bit_idx_r + 3'd1;
                    rstate_nxt_s = (bit_idx_r == 3'd7) ? R_STOP : R_DATA;
                end else if (tick_s) begin
                    samp_nxt_s = samp_cnt_r + 4'd1;
                end else begin
                    samp_nxt_s = samp_cnt_r;
                end
            end
            R_STOP: begin
                if (tick_s && (samp_cnt_r == 4'd15)) begin
                    vld_nxt_s    = rx_sync_r;
                    ferr_nxt_s   = !rx_sync_r;
                    samp_nxt_s   = 4'd0;
                    rstate_nxt_s = R_IDLE;
                end else if (tick_s) begin
                    samp_nxt_s = samp_cnt_r + 4'd1;
                end else begin
                    samp_nxt_s = samp_cnt_r;
                end
            end
            default: begin
                rstate_nxt_s = R_IDLE;
            end
        endcase
    end
endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: receives a length-prefixed little-endian word image over UART,
// writes it into instruction memory and holds the CPU in reset meanwhile.
module uart_prog_loader
    import minisys_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200,
    parameter int ADDR_W   = IMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_mode,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
    localparam logic [WORD_W-1:0] LEN_MAX = WORD_W'(1) << ADDR_W;

    logic [BYTE_W-1:0] rx_byte_s;
    logic              byte_vld_s, frm_err_s;
    ld_state_t         state_r, state_nxt_s;
    logic [1:0]        byte_cnt_r, byte_cnt_nxt_s;
    logic [WORD_W-1:0] word_r, word_nxt_s, len_r, len_nxt_s, asm_s;
    logic [ADDR_W:0]   idx_r, idx_nxt_s, idx_inc_s;
    logic              pm_prev_r, pm_rise_s, pm_fall_s;
    logic              we_r, we_nxt_s, done_r, done_nxt_s, err_r, err_nxt_s;
    logic              busy_r, busy_nxt_s, cpu_rst_r, cpu_rst_nxt_s;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic [WORD_W-1:0] wdata_r, wdata_nxt_s;

    uart_rx_byte #(.TICK_DIV(TICK_DIV)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (uart_rx),
        .data     (rx_byte_s),
        .byte_vld (byte_vld_s),
        .frm_err  (frm_err_s)
    );

    assign asm_s      = {rx_byte_s, word_r[WORD_W-1:BYTE_W]};
    assign idx_inc_s  = idx_r + (ADDR_W + 1)'(1);
    assign pm_rise_s  = prog_mode && !pm_prev_r;
    assign pm_fall_s  = !prog_mode && pm_prev_r;
    assign imem_we    = we_r;
    assign imem_addr  = addr_r;
    assign imem_wdata = wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

    // Loader state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            byte_cnt_r <= 2'd0;
            word_r     <= '0;
            len_r      <= '0;
            idx_r      <= '0;
            pm_prev_r  <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= '0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            cpu_rst_r  <= 1'b1;
        end else begin
            state_r    <= state_nxt_s;
            byte_cnt_r <= byte_cnt_nxt_s;
            word_r     <= word_nxt_s;
            len_r      <= len_nxt_s;
            idx_r      <= idx_nxt_s;
            pm_prev_r  <= prog_mode;
            we_r       <= we_nxt_s;
            addr_r     <= addr_nxt_s;
            wdata_r    <= wdata_nxt_s;
            done_r     <= done_nxt_s;
            err_r      <= err_nxt_s;
            busy_r     <= busy_nxt_s;
            cpu_rst_r  <= cpu_rst_nxt_s;
        end
    end

    // Next state, byte-to-word assembly and write strobe generation
    always_comb begin
        state_nxt_s    = state_r;
        byte_cnt_nxt_s = byte_cnt_r;
        word_nxt_s     = word_r;
        len_nxt_s      = len_r;
        idx_nxt_s      = idx_r;
        we_nxt_s       = 1'b0;
        addr_nxt_s     = addr_r;
        wdata_nxt_s    = wdata_r;
        done_nxt_s     = done_r;
        err_nxt_s      = err_r;
        case (state_r)
            IDLE: begin
                if (pm_rise_s) begin
                    state_nxt_s    = LEN;
                    byte_cnt_nxt_s = 2'd0;
                    done_nxt_s     = 1'b0;
                    err_nxt_s      = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LEN: begin
                if (pm_fall_s || frm_err_s) begin
                    state_nxt_s = ERR;
                    err_nxt_s   = 1'b1;
                end else if (byte_vld_s) begin
                    word_nxt_s     = asm_s;
                    byte_cnt_nxt_s = byte_cnt_r + 2'd1;
                    if (byte_cnt_r != 2'd3) begin
                        state_nxt_s = LEN;
                    end else if (asm_s == '0) begin
                        state_nxt_s = DONE;
                        done_nxt_s  = 1'b1;
                    end else if (asm_s > LEN_MAX) begin
                        state_nxt_s = ERR;
                        err_nxt_s   = 1'b1;
                    end else begin
                        state_nxt_s = DATA;
                        len_nxt_s   = asm_s;
                        idx_nxt_s   = '0;
                    end
                end else begin
                    state_nxt_s = LEN;
                end
            end
            DATA: begin
                if (pm_fall_s || frm_err_s) begin
                    state_nxt_s = ERR;
                    err_nxt_s   = 1'b1;
                end else if (byte_vld_s && (byte_cnt_r == 2'd3)) begin
                    word_nxt_s     = asm_s;
                    byte_cnt_nxt_s = 2'd0;
                    we_nxt_s       = 1'b1;
                    addr_nxt_s     = idx_r[ADDR_W-1:0];
                    wdata_nxt_s    = asm_s;
                    idx_nxt_s      = idx_inc_s;
                    if (WORD_W'(idx_inc_s) == len_r) begin
                        state_nxt_s = DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else if (byte_vld_s) begin
                    word_nxt_s     = asm_s;
                    byte_cnt_nxt_s = byte_cnt_r + 2'd1;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            DONE, ERR: begin
                // Level test lets an abort-driven ERR fall through to IDLE next cycle
                if (!prog_mode) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        busy_nxt_s    = (state_nxt_s == LEN) || (state_nxt_s == DATA);
        cpu_rst_nxt_s = prog_mode || busy_nxt_s || (state_nxt_s == ERR);
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: image vectors table plus hand-written
// sequences for reset, glitch, framing error and mid-load aborts.
module tb_uart_prog_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        prog_mode = 1'b0;
    logic        uart_rx = 1'b1;
    logic        imem_we;
    logic [13:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst, busy, done, err;

    int checks = 0;
    int errors = 0;
    int vld_cnt = 0;
    logic [13:0] wr_addr[$];
    logic [31:0] wr_data[$];

    typedef struct {
        logic [31:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          nsend;
        int          exp_wr;
        logic        exp_done;
        logic        exp_err;
        logic        exp_busy;
        logic        exp_err_post;
    } vec_t;
    vec_t vecs[5];

    uart_prog_loader #(.CLK_FREQ(1600000), .BAUD(100000), .ADDR_W(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_mode  (prog_mode),
        .uart_rx    (uart_rx),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
        if (dut.u_rx.byte_vld === 1'b1) vld_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        clks(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            clks(16);
        end
        uart_rx = stop;
        clks(16);
        uart_rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        vecs[0] = '{32'd2, 32'h12345678, 32'hDEADBEEF, 2, 2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd0, 32'h0, 32'h0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h00004001, 32'h0, 32'h0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{32'd1, 32'hA5C30F01, 32'h0, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h00004000, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1};

        // Reset state
        clks(3);
        chk("rst_we", imem_we, 1'b0);
        chk("rst_addr", imem_addr, 14'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_cpu_rst", cpu_rst, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b1;
        clks(1);
        chk("post_rst_cpu_rst", cpu_rst, 1'b0);

        // Short glitch must not be taken as a start bit
        clks(5);
        uart_rx = 1'b0;
        clks(4);
        uart_rx = 1'b1;
        clks(200);
        chk("glitch_vld", vld_cnt, 0);

        // Table-driven image loads
        for (int v = 0; v < 5; v++) begin
            clear_writes();
            prog_mode = 1'b1;
            clks(3);
            chk($sformatf("v%0d_busy_start", v), busy, 1'b1);
            chk($sformatf("v%0d_cpu_rst_start", v), cpu_rst, 1'b1);
            send_word(vecs[v].n);
            if (vecs[v].nsend > 0) send_word(vecs[v].w0);
            if (vecs[v].nsend > 1) send_word(vecs[v].w1);
            clks(10);
            chk($sformatf("v%0d_wr_count", v), wr_addr.size(), vecs[v].exp_wr);
            for (int i = 0; i < wr_addr.size() && i < vecs[v].exp_wr; i++) begin
                chk($sformatf("v%0d_addr%0d", v, i), wr_addr[i], i);
                chk($sformatf("v%0d_data%0d", v, i), wr_data[i], (i == 0) ? vecs[v].w0 : vecs[v].w1);
            end
            chk($sformatf("v%0d_done", v), done, vecs[v].exp_done);
            chk($sformatf("v%0d_err", v), err, vecs[v].exp_err);
            chk($sformatf("v%0d_busy", v), busy, vecs[v].exp_busy);
            chk($sformatf("v%0d_cpu_rst", v), cpu_rst, 1'b1);
            prog_mode = 1'b0;
            clks(3);
            chk($sformatf("v%0d_cpu_rst_run", v), cpu_rst, 1'b0);
            chk($sformatf("v%0d_busy_run", v), busy, 1'b0);
            chk($sformatf("v%0d_done_post", v), done, vecs[v].exp_done);
            chk($sformatf("v%0d_err_post", v), err, vecs[v].exp_err_post);
        end

        // Framing error after N=1
        clear_writes();
        prog_mode = 1'b1;
        clks(3);
        send_word(32'd1);
        send_byte(8'h55, 1'b0);
        clks(20);
        chk("frm_err", err, 1'b1);
        chk("frm_wr_count", wr_addr.size(), 0);
        chk("frm_cpu_rst", cpu_rst, 1'b1);
        chk("frm_busy", busy, 1'b0);
        prog_mode = 1'b0;
        clks(3);
        chk("frm_err_sticky", err, 1'b1);
        chk("frm_cpu_rst_run", cpu_rst, 1'b0);
        prog_mode = 1'b1;
        clks(2);
        chk("frm_err_clear", err, 1'b0);
        send_word(32'd0);
        clks(5);
        chk("frm_reload_done", done, 1'b1);
        prog_mode = 1'b0;
        clks(3);

        // prog_mode dropped after 6 data bytes
        clear_writes();
        prog_mode = 1'b1;
        clks(3);
        send_word(32'd2);
        send_word(32'hCAFEF00D);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        clks(5);
        prog_mode = 1'b0;
        clks(1);
        chk("drop_err", err, 1'b1);
        clks(3);
        chk("drop_wr_count", wr_addr.size(), 1);
        if (wr_addr.size() > 0) begin
            chk("drop_addr0", wr_addr[0], 14'd0);
            chk("drop_data0", wr_data[0], 32'hCAFEF00D);
        end
        chk("drop_err_idle", err, 1'b1);
        chk("drop_busy", busy, 1'b0);

        // Reset pulsed mid-word
        clear_writes();
        prog_mode = 1'b1;
        clks(3);
        send_word(32'd2);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        rst = 1'b0;
        prog_mode = 1'b0;
        clks(2);
        chk("mid_rst_cpu_rst", cpu_rst, 1'b1);
        rst = 1'b1;
        send_byte(8'h03, 1'b1);
        send_byte(8'h04, 1'b1);
        clks(10);
        chk("mid_rst_wr_count", wr_addr.size(), 0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cpu_rst_run", cpu_rst, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Upstream boot stage of minisys1a: receives a program image over UART and writes it word-by-word into instruction memory.
- Holds the CPU in reset while programming is in progress, and releases it once the image is complete.
- Sits between the board UART RX pin and the minisys1a instruction-memory write port / CPU reset input.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, UART baud rate; 8N1 framing, LSB first.
- ADDR_W, 14, instruction-memory word-address width.
- Derived constant TICK_DIV = CLK_FREQ/(BAUD*16), the 16x oversample divider; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- prog_mode  in  1  level; 1 = accept image, 0 = normal run.
- uart_rx  in  1  asynchronous serial input; idles high.
- imem_we  out  1  one-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address, valid with imem_we.
- imem_wdata  out  32  word data, valid with imem_we.
- cpu_rst  out  1  active-high reset driven to minisys1a.
- busy  out  1  high in LEN or DATA.
- done  out  1  sticky: last image loaded successfully.
- err  out  1  sticky: last load aborted.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE; imem_we=0; imem_addr=0; imem_wdata=0.
  - cpu_rst=1; busy=0; done=0; err=0.
  - RX synchroniser preset to 1.
- RX front end:
  - uart_rx passes through a 2-flop synchroniser.
  - Tick counter wraps at TICK_DIV-1.
  - A start bit is a falling edge that is still 0 at sample 8.
  - Each data bit is sampled at the 8th tick of its bit.
  - Stop bit sampled 0 -> framing error; byte is discarded.
  - Valid byte -> 1-cycle byte_vld pulse.
- Frame format:
  - 4-byte little-endian word count N, then N words.
  - Each word is 4 bytes, little-endian.
- FSM states and transitions:
  - IDLE: on rising edge of prog_mode -> LEN; clear done and err; byte_cnt=0.
  - LEN: assemble N.
    - N=0 -> DONE.
    - N > 2^ADDR_W -> ERR.
    - Otherwise -> DATA with addr=0.
  - DATA: on every 4th byte, assert imem_we for exactly one cycle, with imem_wdata = assembled word and imem_addr = word index. Then increment the index. When index reaches N -> DONE.
  - DONE: done=1.
  - ERR: err=1.
  - From DONE or ERR: prog_mode falling -> IDLE.
- Any framing error in LEN or DATA -> ERR.
- prog_mode falling while in LEN or DATA -> ERR, then IDLE on the following cycle. The partial image stays in memory.
- Write latency: imem_we asserts 1 clk after the byte_vld of the word's 4th byte.
- cpu_rst = !rst OR prog_mode OR busy OR (state==ERR). The CPU restarts at PC 0 when prog_mode drops after DONE.
- A reset mid-load aborts the load. No write is issued on the reset cycle.
- Bytes received in IDLE, DONE or ERR are ignored.
- Word index never wraps; the N bound guarantees this.

Decomposition:
- Shared package (minisys_pkg) holds:
  - the state enum {IDLE, LEN, DATA, DONE, ERR};
  - the byte and word width constants;
  - the IMEM_ADDR_W constant shared with minisys1a.
- One sub-module: uart_rx_byte (oversampling receiver; outputs byte, byte_vld, frm_err).
- The FSM and word assembler stay in the top module.

Test Plan:
- Bench configuration for all scenarios: CLK_FREQ=1600000, BAUD=100000, so TICK_DIV=1 and a bit lasts 16 clks.
- Reset held for 3 clks with prog_mode=0 -> all outputs at reset values. cpu_rst=1 during reset; cpu_rst=0 one clk after rst rises.
- prog_mode=1, send N=2 then 0x12345678 and 0xDEADBEEF (LE bytes) -> exactly two imem_we pulses: addr0=0x12345678, addr1=0xDEADBEEF. Then done=1, busy=0, cpu_rst=1 until prog_mode=0, then cpu_rst=0.
- N=0 -> DONE immediately, no imem_we, done=1.
- Send N=1, then a byte whose stop bit is 0 -> err=1, no imem_we, cpu_rst stays 1. prog_mode=0 -> IDLE; err stays 1 until the next prog_mode rise.
- prog_mode dropped after 6 data bytes of N=2 -> one write (addr 0), err=1. Repeat with rst=0 pulsed mid-word instead -> no further write, all flags 0.
- N=0x00004001 with ADDR_W=14 -> ERR without any write. Glitch on uart_rx of 4 clks low -> no byte_vld.
